// File: rtl/shift_pkg.sv
// Shared definitions for the shift-register family: mode field type and encodings.
package shift_pkg;

  typedef logic [1:0] shift_mode_t;

  localparam shift_mode_t MODE_HOLD = 2'b00;
  localparam shift_mode_t MODE_SHR  = 2'b01;
  localparam shift_mode_t MODE_SHL  = 2'b10;
  localparam shift_mode_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/shift_frame_cnt.sv
// Modulo-N step counter with synchronous clear and a registered wrap pulse,
// asserted in the cycle after the N-th counted step.
module shift_frame_cnt #(
  parameter int N = 8,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic step,
  output logic wrap
);

  logic [CW-1:0] cnt_p1;
  logic          last;

  assign last = (cnt_p1 == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p1 <= '0;
      wrap   <= 1'b0;
    end else begin
      wrap <= step && last;
      if (clr) begin
        cnt_p1 <= '0;
      end else if (step) begin
        cnt_p1 <= last ? '0 : cnt_p1 + 1'b1;
      end
    end
  end

endmodule

// File: rtl/shift_reg_univ.sv
// Parametrised universal shift register: hold, shift right/left with optional
// rotate, parallel load, registered serial outputs and a frame-complete pulse.
module shift_reg_univ
  import shift_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               LANE_W  = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  shift_mode_t       mode,
  input  logic              rot,
  input  logic [LANE_W-1:0] si_r,
  input  logic [LANE_W-1:0] si_l,
  input  logic [WIDTH-1:0]  pdata,
  output logic [WIDTH-1:0]  q,
  output logic [LANE_W-1:0] so_r,
  output logic [LANE_W-1:0] so_l,
  output logic              frame_done
);

  localparam int N = WIDTH / LANE_W;

  if ((WIDTH % LANE_W) != 0 || LANE_W >= WIDTH || LANE_W < 1) begin : g_bad_params
    $fatal(1, "shift_reg_univ: WIDTH must be a multiple of LANE_W and 1 <= LANE_W < WIDTH");
  end

  logic [WIDTH-1:0]  q_p1;
  logic [LANE_W-1:0] so_r_p1;
  logic [LANE_W-1:0] so_l_p1;
  logic [LANE_W-1:0] lsb_lane;
  logic [LANE_W-1:0] msb_lane;
  logic [LANE_W-1:0] in_r;
  logic [LANE_W-1:0] in_l;
  logic              do_shift;
  logic              do_load;

  assign lsb_lane = q_p1[LANE_W-1:0];
  assign msb_lane = q_p1[WIDTH-1:WIDTH-LANE_W];
  assign in_r     = rot ? lsb_lane : si_r;
  assign in_l     = rot ? msb_lane : si_l;
  assign do_shift = en && (mode == MODE_SHR || mode == MODE_SHL);
  assign do_load  = en && (mode == MODE_LOAD);

  // Stage p1: register contents and exited lanes
  always_ff @(posedge clk) begin
    if (rst) begin
      q_p1    <= RST_VAL;
      so_r_p1 <= '0;
      so_l_p1 <= '0;
    end else if (en) begin
      case (mode)
        MODE_SHR: begin
          q_p1    <= {in_r, q_p1[WIDTH-1:LANE_W]};
          so_r_p1 <= lsb_lane;
        end
        MODE_SHL: begin
          q_p1    <= {q_p1[WIDTH-LANE_W-1:0], in_l};
          so_l_p1 <= msb_lane;
        end
        MODE_LOAD: q_p1 <= pdata;
        default: ;
      endcase
    end
  end

  shift_frame_cnt #(.N(N)) u_frame_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (do_load),
    .step (do_shift),
    .wrap (frame_done)
  );

  assign q    = q_p1;
  assign so_r = so_r_p1;
  assign so_l = so_l_p1;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Scoreboard bench: two instances (lane width 1 and 2) share stimulus and are
// checked every cycle against an arithmetic reference model.
module tb_shift_reg_univ;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       rot = 1'b0;
  logic [1:0] si_r = 2'b00;
  logic [1:0] si_l = 2'b00;
  logic [7:0] pdata = 8'h00;

  logic [7:0] q0, q1;
  logic       so_r0, so_l0, fd0, fd1;
  logic [1:0] so_r1, so_l1;

  always #5 clk = ~clk;

  shift_reg_univ #(.WIDTH(8), .LANE_W(1), .RST_VAL(8'h00)) dut0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .rot(rot),
    .si_r(si_r[0]), .si_l(si_l[0]), .pdata(pdata),
    .q(q0), .so_r(so_r0), .so_l(so_l0), .frame_done(fd0)
  );

  shift_reg_univ #(.WIDTH(8), .LANE_W(2), .RST_VAL(8'h00)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .rot(rot),
    .si_r(si_r), .si_l(si_l), .pdata(pdata),
    .q(q1), .so_r(so_r1), .so_l(so_l1), .frame_done(fd1)
  );

  // Reference model state, one entry per instance
  int mq[2], msr[2], msl[2], mshifts[2], mfd[2];
  int exp_q0[$], exp_q1[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  function automatic int pack(int fd, int sl, int sr, int qv);
    return (fd << 12) | (sl << 10) | (sr << 8) | qv;
  endfunction

  task automatic model(input int i);
    int l, n, mask, lane_out, lane_in;
    l    = (i == 0) ? 1 : 2;
    n    = 8 / l;
    mask = (1 << l) - 1;
    if (rst) begin
      mq[i] = 0; msr[i] = 0; msl[i] = 0; mshifts[i] = 0; mfd[i] = 0;
    end else if (!en || mode == 2'b00) begin
      mfd[i] = 0;
    end else if (mode == 2'b11) begin
      mq[i] = int'(pdata); mshifts[i] = 0; mfd[i] = 0;
    end else begin
      if (mode == 2'b01) begin
        lane_out = mq[i] % (1 << l);
        lane_in  = rot ? lane_out : (int'(si_r) & mask);
        mq[i]    = lane_in * (1 << (8 - l)) + mq[i] / (1 << l);
        msr[i]   = lane_out;
      end else begin
        lane_out = mq[i] / (1 << (8 - l));
        lane_in  = rot ? lane_out : (int'(si_l) & mask);
        mq[i]    = (mq[i] * (1 << l)) % 256 + lane_in;
        msl[i]   = lane_out;
      end
      mshifts[i] = mshifts[i] + 1;
      mfd[i]     = (mshifts[i] == n) ? 1 : 0;
      if (mshifts[i] == n) mshifts[i] = 0;
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [1:0] m, input logic ro,
                      input logic [1:0] sr, input logic [1:0] sl, input logic [7:0] pd);
    rst = r; en = e; mode = m; rot = ro; si_r = sr; si_l = sl; pdata = pd;
    model(0);
    model(1);
    @(posedge clk);
    exp_q0.push_back(pack(mfd[0], msl[0], msr[0], mq[0]));
    exp_q1.push_back(pack(mfd[1], msl[1], msr[1], mq[1]));
    #1;
  endtask

  task automatic compare(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle %0d: got fd=%0d so_l=%0d so_r=%0d q=%02h, want fd=%0d so_l=%0d so_r=%0d q=%02h",
               name, cyc, act >> 12, (act >> 10) & 3, (act >> 8) & 3, act & 255,
               expv >> 12, (expv >> 10) & 3, (expv >> 8) & 3, expv & 255);
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        cyc++;
        if (exp_q0.size() > 0)
          compare("lane1", pack(int'(fd0), int'(so_l0), int'(so_r0), int'(q0)), exp_q0.pop_front());
        if (exp_q1.size() > 0)
          compare("lane2", pack(int'(fd1), int'(so_l1), int'(so_r1), int'(q1)), exp_q1.pop_front());
      end
    join_none

    // Reset held two cycles, then idle with en=0
    repeat (2) step(1, 0, 2'b00, 0, 2'b00, 2'b00, 8'h00);
    repeat (3) step(0, 0, 2'b01, 0, 2'b11, 2'b11, 8'hFF);

    // Fill from reset with ones shifting right
    repeat (8) step(0, 1, 2'b01, 0, 2'b11, 2'b00, 8'h00);

    // Load then one right rotate; the following load clears the frame count
    step(0, 1, 2'b11, 0, 2'b00, 2'b00, 8'hA5);
    step(0, 1, 2'b01, 1, 2'b00, 2'b00, 8'h00);
    step(0, 1, 2'b11, 0, 2'b00, 2'b00, 8'hA5);

    // Left shifts with si_l=11, a full lane-2 frame and beyond
    repeat (8) step(0, 1, 2'b10, 0, 2'b00, 2'b11, 8'h00);

    // Abort a frame with reset, then a full frame
    repeat (3) step(0, 1, 2'b01, 0, 2'b10, 2'b00, 8'h00);
    step(1, 1, 2'b01, 0, 2'b10, 2'b00, 8'h00);
    repeat (9) step(0, 1, 2'b01, 0, 2'b01, 2'b00, 8'h00);

    // Mid-frame freeze, then direction changes
    step(0, 1, 2'b11, 0, 2'b00, 2'b00, 8'h3C);
    repeat (3) step(0, 1, 2'b01, 0, 2'b01, 2'b00, 8'h00);
    repeat (5) step(0, 0, 2'($urandom_range(1, 3)), 1'($urandom), 2'($urandom), 2'($urandom), 8'($urandom));
    repeat (2) step(0, 1, 2'b01, 0, 2'b10, 2'b00, 8'h00);
    repeat (6) step(0, 1, 2'b10, 1, 2'b00, 2'b01, 8'h00);
    repeat (2) step(0, 1, 2'b00, 0, 2'b11, 2'b11, 8'hFF);

    // Randomised traffic with occasional reset, holds and loads
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
           1'($urandom), 2'($urandom), 2'($urandom), 8'($urandom));
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d entries left, want 0/0", exp_q0.size(), exp_q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
